stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter: NUM_CH, default 4, number of input channels (range 2..16).
REQ-002 Parameter: DATA_W, default 8, payload width per channel in bits (range 1..64).
REQ-003 Parameter: SEL_W, default $clog2(NUM_CH), width of channel index.
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 Port: sel  input  SEL_W  channel index used in fixed mode.
REQ-008 Port: in_valid  input  NUM_CH  per-channel valid.
REQ-009 Port: in_ready  output  NUM_CH  per-channel ready; at most one bit high.
REQ-010 Port: in_data  input  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W].
REQ-011 Port: out_valid  output  1  output register holds a beat.
REQ-012 Port: out_ready  input  1  downstream accepts the beat.
REQ-013 Port: out_data  output  DATA_W  registered payload.
REQ-014 Port: out_ch  output  SEL_W  index of the channel that supplied out_data.

Function
REQ-015 Transfer on a port occurs in a cycle where valid and ready are both high at the rising edge.
REQ-016 Output stage: single-entry register; load_en = !out_valid || out_ready (accept while draining, no bubble).
REQ-017 Fixed mode: grant = sel when in_valid[sel]=1 and sel < NUM_CH; otherwise no grant.
REQ-018 Round-robin mode: grant = first i with in_valid[i]=1 searching last_grant+1, last_grant+2, ... modulo NUM_CH.
REQ-019 in_ready[grant] = load_en; all other in_ready bits 0; in_ready is combinational from in_valid, mode, sel, last_grant, out_valid, out_ready.
REQ-020 On an input transfer: out_data <= granted payload, out_ch <= grant, out_valid <= 1, next cycle (latency 1).
REQ-021 Output transfer with no input transfer in same cycle: out_valid <= 0; out_data, out_ch hold.
REQ-022 Simultaneous output and input transfer: out_valid stays 1, new beat replaces old, sustaining 1 beat/cycle.
REQ-023 out_valid=1 and out_ready=0: out_data, out_ch, out_valid hold stable; all in_ready 0.
REQ-024 last_grant updates to grant only on an input transfer, in both modes; unchanged otherwise.
REQ-025 Wrap-around: last_grant = NUM_CH-1 searches from channel 0.
REQ-026 mode or sel change takes effect in the same cycle's grant computation; a beat already in the output register is unaffected.
REQ-027 No in_valid bits set: no grant, no state change other than REQ-021.

Reset
REQ-028 rst_n=0 asynchronously forces out_valid=0, out_data=0, out_ch=0, last_grant=NUM_CH-1, regardless of clk.
REQ-029 While rst_n=0, all in_ready bits are 0.
REQ-030 Reset mid-transfer discards the held beat; first grant after release in round-robin mode favours channel 0.

Structure
REQ-031 Shared package stream_mux_pkg holds MODE_FIXED=1'b0, MODE_RR=1'b1 constants and default NUM_CH/DATA_W values.
REQ-032 Round-robin priority search in sub-module rr_arbiter (inputs req, last_grant; outputs grant, grant_vld); purely combinational.
REQ-033 All sequential state in stream_mux_rr top; no latches; no derived clocks.

Verification
REQ-034 Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately, in_ready=0.
REQ-035 Fixed mode: mode=0, sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=2; in_ready=4'b0100.
REQ-036 Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, no gaps.
REQ-037 Sparse requests: mode=1, last_grant=1, in_valid=4'b0001 -> grant 0 (wrap); then in_valid=4'b1001 -> grant 3.
REQ-038 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=0, last_grant unchanged; out_ready=1 -> drain and reload same cycle.
REQ-039 Invalid select: NUM_CH=3, mode=0, sel=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search starting just above last_grant.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_grant,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_vld
);

    // The first pass finds the lowest requester overall (the wrap-around
    // winner); the second overrides it with the lowest one above last_grant.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = SEL_W'(i);
                grant_vld = 1'b1;
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i] && (SEL_W'(i) > last_grant)) begin
                grant = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with fixed or round-robin selection
// and a single-entry registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch
);

    logic [SEL_W-1:0]  last_grant;
    logic [SEL_W-1:0]  rr_grant;
    logic              rr_vld;
    logic              fix_vld;
    logic [SEL_W-1:0]  grant;
    logic              grant_vld;
    logic              load_en;
    logic              in_xfer;
    logic [DATA_W-1:0] payload;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req        (in_valid),
        .last_grant (last_grant),
        .grant      (rr_grant),
        .grant_vld  (rr_vld)
    );

    // Fixed select only grants an in-range channel that is actually valid.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((sel == SEL_W'(i)) && in_valid[i]) begin
                fix_vld = 1'b1;
            end
        end
    end

    assign grant     = (mode == MODE_RR) ? rr_grant : sel;
    assign grant_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
    assign load_en   = !out_valid || out_ready;
    assign in_xfer   = rst_n && grant_vld && load_en;

    always_comb begin
        payload  = '0;
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                payload     = in_data[i*DATA_W +: DATA_W];
                in_ready[i] = in_xfer;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
        end else if (in_xfer) begin
            out_valid  <= 1'b1;
            out_data   <= payload;
            out_ch     <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr (4-channel and 3-channel builds).
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [23:0] in_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .out_ch    (out_ch3)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] iv,
                                input logic ordy, input logic [3:0] rdy, input logic ov,
                                input logic [7:0] od, input logic [1:0] ch);
        vec_t v;
        v.mode = m; v.sel = s; v.iv = iv; v.ordy = ordy;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_od = od; v.exp_ch = ch;
        return v;
    endfunction

    initial begin
        // ch0=11 ch1=22 ch2=A5 ch3=44; pointer starts at 3 after reset
        tbl[0]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        tbl[1]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        tbl[2]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        tbl[3]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        tbl[4]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
        tbl[5]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        tbl[6]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        tbl[7]  = mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0);
        tbl[8]  = mk(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
        tbl[9]  = mk(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        tbl[10] = mk(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
        tbl[11] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3);
        tbl[12] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3);
        tbl[13] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3);
        tbl[14] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
        tbl[15] = mk(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0);
        tbl[16] = mk(1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3);
        tbl[17] = mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3);

        in_data   = 32'h44A5_2211;
        in_data3  = 24'hA5_2211;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        mode3     = 1'b0;
        sel3      = 2'd0;
        in_valid3 = 3'b000;
        out_ready3 = 1'b1;
        rst_n     = 1'b0;

        // In reset with requests pending: nothing granted, outputs cleared.
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", 32'(out_data), 32'h0);
        chk("reset_out_ch", 32'(out_ch), 32'h0);
        @(posedge clk);
        #1;
        chk("reset_hold_out_valid", 32'(out_valid), 32'h0);
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            mode      = tbl[i].mode;
            sel       = tbl[i].sel;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_od));
            chk($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(tbl[i].exp_ch));
        end

        // Asynchronous reset mid-cycle while a beat is held.
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_data", 32'(out_data), 32'h0);
        chk("midrst_out_ch", 32'(out_ch), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("postrst_out_valid", 32'(out_valid), 32'h1);
        chk("postrst_out_data", 32'(out_data), 32'h11);
        chk("postrst_out_ch", 32'(out_ch), 32'h0);

        // Three-channel build: out-of-range select grants nothing.
        mode3     = 1'b0;
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        #1;
        chk("sel3_in_ready", 32'(in_ready3), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("sel3_out_valid", 32'(out_valid3), 32'h0);
        sel3 = 2'd2;
        #1;
        chk("sel2_in_ready", 32'(in_ready3), 32'h4);
        @(posedge clk);
        #1;
        chk("sel2_out_valid", 32'(out_valid3), 32'h1);
        chk("sel2_out_data", 32'(out_data3), 32'hA5);
        chk("sel2_out_ch", 32'(out_ch3), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
